cd_ram_reader: RTL and testbench



---
 rtl/cd_ram_reader_pkg.sv | 21 ++
 rtl/cd_skid2.sv | 72 +++++++
 rtl/cd_ram_reader.sv | 168 ++++++++++++++++
 tb/tb_cd_ram_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_ram_reader_pkg.sv
// Shared definitions for the paged frame buffer read-side drain engine.
//   - state_t : FSM state encoding, also visible on the debug state port.
//   - LEN_MSB : default page address width; the payload length sits in
//               flags[LEN_MSB:0], one bit wider than the page address so a
//               completely full page can be described.
//   - SKID_W  : width of one skid buffer entry, {last, data[7:0]}.
package cd_ram_reader_pkg;

  localparam int LEN_MSB = 8;
  localparam int SKID_W  = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LOAD   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

endpackage

// File: rtl/cd_skid2.sv
// Two-entry valid/ready buffer holding {last, data} words for the byte stream.
// The head register drives the pop side directly, so pop_valid/pop_data are
// registered. A spare register absorbs one extra word while the sink stalls.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 drop both entries (takes priority over push)
//   push_valid/push_data  write side; the producer never pushes into a full
//                         buffer (it tracks occupancy itself)
//   pop_valid/pop_data    head word
//   pop_ready             sink accepts the head when pop_valid && pop_ready
//   occupancy             number of words held (0..2)
//
// Handshake: a word moves on the pop side in every cycle where
// pop_valid && pop_ready; pop_data is held stable while pop_valid && !pop_ready.
module cd_skid2
  import cd_ram_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push_valid,
  input  logic [SKID_W-1:0] push_data,
  output logic              pop_valid,
  output logic [SKID_W-1:0] pop_data,
  input  logic              pop_ready,
  output logic [1:0]        occupancy
);

  logic              head_v_q;
  logic              spare_v_q;
  logic [SKID_W-1:0] head_q;
  logic [SKID_W-1:0] spare_q;
  logic              pop;

  assign pop = head_v_q && pop_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_v_q  <= 1'b0;
      spare_v_q <= 1'b0;
      head_q    <= '0;
      spare_q   <= '0;
    end else if (flush) begin
      head_v_q  <= 1'b0;
      spare_v_q <= 1'b0;
    end else if (!head_v_q) begin
      // The spare is only ever filled behind a valid head, so it is empty here.
      if (push_valid) begin
        head_q   <= push_data;
        head_v_q <= 1'b1;
      end
    end else if (pop) begin
      if (spare_v_q) begin
        head_q    <= spare_q;
        spare_v_q <= push_valid;
        if (push_valid) spare_q <= push_data;
      end else begin
        head_v_q <= push_valid;
        if (push_valid) head_q <= push_data;
      end
    end else if (push_valid) begin
      spare_q   <= push_data;
      spare_v_q <= 1'b1;
    end
  end

  assign pop_valid = head_v_q;
  assign pop_data  = head_q;
  assign occupancy = {1'b0, head_v_q} + {1'b0, spare_v_q};

endmodule

// File: rtl/cd_ram_reader.sv
// Read-side drain engine of the paged frame buffer. Waits for a committed
// page, latches its flags, takes the payload length from the flags and streams
// the page bytes to a byte-serial transmitter, then releases the page.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   en                allow starting a new page (looked at only in IDLE)
//   abort             one-cycle pulse: drop current page, flush the buffer
//   unread            buffer holds at least one committed page
//   rd_byte           page byte, one cycle after rd_addr/rd_en
//   rd_flags          flags of the current read page, registered
//   rd_addr, rd_en    byte read address within the page and read strobe
//   rd_done           one-cycle pulse: page consumed, advance read page
//   rd_done_all       one-cycle pulse: clear all pages and pointers
//   cur_flags         flags latched for the page being streamed
//   tx_data, tx_valid, tx_last, tx_ready   outgoing byte stream
//   busy              high in every state except IDLE
//   dbg_state         current FSM state (state_t encoding)
//
// Stream handshake: a byte transfers in every cycle where tx_valid && tx_ready.
// While tx_valid && !tx_ready, tx_data and tx_last hold; tx_valid only drops
// after a transfer, or on abort/reset.
module cd_ram_reader
  import cd_ram_reader_pkg::*;
#(
  parameter int A_WIDTH = LEN_MSB
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               abort,
  input  logic               unread,
  input  logic [7:0]         rd_byte,
  input  logic [15:0]        rd_flags,
  output logic [A_WIDTH-1:0] rd_addr,
  output logic               rd_en,
  output logic               rd_done,
  output logic               rd_done_all,
  output logic [15:0]        cur_flags,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               tx_last,
  input  logic               tx_ready,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam logic [A_WIDTH:0] PAGE_BYTES = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH:0] CNT_ONE    = (A_WIDTH+1)'(1);
  localparam logic [A_WIDTH:0] CNT_ZERO   = '0;

  state_t             state_q;
  state_t             state_d;
  logic [A_WIDTH-1:0] rd_addr_q;
  logic [A_WIDTH:0]   issue_rem_q;
  logic [A_WIDTH:0]   send_rem_q;
  logic               in_flight_q;
  logic               in_flight_last_q;
  logic [15:0]        cur_flags_q;

  logic [A_WIDTH:0]   len_raw;
  logic [A_WIDTH:0]   len;
  logic [1:0]         occ;
  logic               pop;
  logic               issue;
  logic               final_pop;
  logic [SKID_W-1:0]  skid_head;

  // Length field is one bit wider than the page address; anything beyond a
  // full page is clamped to a full page.
  assign len_raw = rd_flags[A_WIDTH:0];
  assign len     = (len_raw > PAGE_BYTES) ? PAGE_BYTES : len_raw;

  assign pop = tx_valid && tx_ready;

  // At most two words may be held or in flight. A handshake in this cycle
  // frees a slot, which is what lets the loop sustain one byte per clock.
  assign issue = (state_q == S_STREAM) && !abort && (issue_rem_q != CNT_ZERO) &&
                 (({1'b0, occ} + {2'b00, in_flight_q}) < (3'd2 + {2'b00, pop}));

  assign final_pop = (state_q == S_STREAM) && pop && (send_rem_q == CNT_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      rd_addr_q        <= '0;
      issue_rem_q      <= '0;
      send_rem_q       <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      cur_flags_q      <= '0;
    end else begin
      state_q          <= state_d;
      in_flight_q      <= issue;
      // The last tag travels with the read, so the skid head carries it
      // exactly when send-remaining reaches one.
      in_flight_last_q <= issue && (issue_rem_q == CNT_ONE);
      if (state_q == S_LOAD) begin
        cur_flags_q <= rd_flags;
        rd_addr_q   <= '0;
        issue_rem_q <= len;
        send_rem_q  <= len;
      end else begin
        if (issue) begin
          rd_addr_q   <= rd_addr_q + A_WIDTH'(1);
          issue_rem_q <= issue_rem_q - CNT_ONE;
        end
        if (pop) send_rem_q <= send_rem_q - CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_en       = issue;
    rd_done     = 1'b0;
    rd_done_all = abort;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (!abort && unread && en) state_d = S_ARM;
      end
      S_ARM: begin
        state_d = abort ? S_GAP : S_LOAD;
      end
      S_LOAD: begin
        if (abort)                state_d = S_GAP;
        else if (len == CNT_ZERO) state_d = S_DONE;
        else                      state_d = S_STREAM;
      end
      S_STREAM: begin
        // Abort wins over a final handshake: the byte is delivered but the
        // page is released only through rd_done_all.
        if (abort)          state_d = S_GAP;
        else if (final_pop) state_d = S_DONE;
      end
      S_DONE: begin
        rd_done = !abort;
        state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  cd_skid2 u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (abort),
    .push_valid (in_flight_q),
    .push_data  ({in_flight_last_q, rd_byte}),
    .pop_valid  (tx_valid),
    .pop_data   (skid_head),
    .pop_ready  (tx_ready),
    .occupancy  (occ)
  );

  assign tx_last   = skid_head[8];
  assign tx_data   = skid_head[7:0];
  assign rd_addr   = rd_addr_q;
  assign cur_flags = cur_flags_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cd_ram_reader.sv
module tb_cd_ram_reader;
  import cd_ram_reader_pkg::*;

  localparam int AW  = 8;
  localparam int NPG = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          abort;
  logic          unread;
  logic [7:0]    rd_byte = '0;
  logic [15:0]   rd_flags = '0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          rd_done;
  logic          rd_done_all;
  logic [15:0]   cur_flags;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready;
  logic          busy;
  logic [2:0]    dbg_state;

  cd_ram_reader #(.A_WIDTH(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .abort       (abort),
    .unread      (unread),
    .rd_byte     (rd_byte),
    .rd_flags    (rd_flags),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_done     (rd_done),
    .rd_done_all (rd_done_all),
    .cur_flags   (cur_flags),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- page buffer environment ----------------
  logic [7:0]  pmem   [NPG][256];
  logic [15:0] pflags [NPG];
  int pushed_pages   = 0;
  int released_pages = 0;

  assign unread = (pushed_pages != released_pages);

  always @(posedge clk) begin
    if (!reset_n)         released_pages <= pushed_pages;
    else if (rd_done_all) released_pages <= pushed_pages;
    else if (rd_done)     released_pages <= released_pages + 1;
    rd_flags <= pflags[released_pages % NPG];
    if (rd_en) rd_byte <= pmem[released_pages % NPG][rd_addr];
  end

  // ---------------- scoreboard ----------------
  logic [8:0]  exp_q[$];
  logic [15:0] exp_f_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  int cyc = 0, first_busy = -1, first_valid = -1;
  int done_cnt = 0, all_cnt = 0, issued = 0, sent = 0, gaps = 0, prev_hs = -1;
  logic       hold_pending = 1'b0;
  logic [8:0] hold_word = '0;
  int         ready_mode = 0;
  int         pat_i = 0;
  logic [5:0] pat_bits = 6'b101001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_test();
    first_busy = -1; first_valid = -1; done_cnt = 0; all_cnt = 0;
    issued = 0; sent = 0; gaps = 0; prev_hs = -1; hold_pending = 1'b0;
  endtask

  // Reference: a page of flags f delivers min(f[8:0], 256) bytes in address
  // order, last set only on the final one, with cur_flags == f throughout.
  task automatic add_page(input logic [15:0] f, input int ascending);
    int slot;
    int len;
    slot = pushed_pages % NPG;
    pflags[slot] = f;
    len = int'(f[8:0]);
    if (len > 256) len = 256;
    for (int i = 0; i < 256; i++)
      pmem[slot][i] = (ascending != 0) ? 8'(8'h11 + i) : 8'($urandom_range(0, 255));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), pmem[slot][i]});
      exp_f_q.push_back(f);
    end
    pushed_pages++;
  endtask

  task automatic tick();
    logic [8:0]  e;
    logic [15:0] ef;
    @(negedge clk);
    cyc++;
    if (busy && first_busy < 0) first_busy = cyc;
    if (tx_valid && first_valid < 0) first_valid = cyc;
    if (rd_done) done_cnt++;
    if (rd_done_all) all_cnt++;
    if (hold_pending) begin
      chk("stall_valid", tx_valid, 1);
      chk("stall_word", {tx_last, tx_data}, hold_word);
    end
    if (tx_valid && tx_ready) begin
      sent++;
      if (prev_hs >= 0 && cyc - prev_hs > 1) gaps++;
      prev_hs = cyc;
      chk("byte_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ef = exp_f_q.pop_front();
        chk("tx_data", tx_data, e[7:0]);
        chk("tx_last", tx_last, e[8]);
        chk("cur_flags", cur_flags, ef);
      end
    end
    if (rd_en) begin
      issued++;
      chk("outstanding_le2", (issued - sent) <= 2, 1);
    end
    hold_pending = tx_valid && !tx_ready && !abort;
    hold_word    = {tx_last, tx_data};
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ready();
    if (ready_mode == 1) tx_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) begin
      tx_ready = pat_bits[pat_i % 6];
      pat_i++;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    do begin
      drive_ready();
      tick();
      n++;
    end while (!(!busy && pushed_pages == released_pages) && n < max_cyc);
    chk("idle_reached", !busy && pushed_pages == released_pages, 1);
  endtask

  task automatic wait_sent(input int target, input int max_cyc);
    int n;
    n = 0;
    while (sent < target && n < max_cyc) begin
      tick();
      n++;
    end
    chk("sent_reached", sent >= target, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f;
    int n;
    reset_n = 1'b0; en = 1'b1; abort = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_cur_flags", cur_flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, S_IDLE);
    reset_n = 1'b1;
    tick(); tick();

    // 5-byte page, ascending bytes 0x11..0x15, sink always ready
    start_test(); ready_mode = 0; tx_ready = 1'b1;
    add_page(16'h0005, 1);
    wait_idle(200);
    chk("t1_latency", first_valid - first_busy, 4);
    chk("t1_sent", sent, 5);
    chk("t1_gaps", gaps, 0);
    chk("t1_done", done_cnt, 1);
    chk("t1_cur_flags", cur_flags, 16'h0005);
    chk("t1_exp_empty", exp_q.size(), 0);

    // Full 256-byte page
    start_test();
    add_page(16'h0100, 0);
    wait_idle(600);
    chk("t2_sent", sent, 256);
    chk("t2_issued", issued, 256);
    chk("t2_gaps", gaps, 0);
    chk("t2_addr_wrap", rd_addr, 0);
    chk("t2_done", done_cnt, 1);
    chk("t2_exp_empty", exp_q.size(), 0);

    // Oversized length field clamps to a full page
    start_test();
    add_page(16'hA1C0, 0);
    wait_idle(600);
    chk("t3_sent", sent, 256);
    chk("t3_done", done_cnt, 1);
    chk("t3_exp_empty", exp_q.size(), 0);

    // Empty page
    start_test();
    add_page(16'h7000, 0);
    wait_idle(50);
    chk("t4_no_valid", first_valid, 32'hFFFF_FFFF);
    chk("t4_done", done_cnt, 1);
    chk("t4_state", dbg_state, S_IDLE);
    chk("t4_cur_flags", cur_flags, 16'h7000);

    // 3-byte page with sink ready pattern 1,0,0,1,0,1
    start_test(); ready_mode = 2; pat_i = 0;
    add_page(16'h0003, 0);
    wait_idle(100);
    chk("t5_sent", sent, 3);
    chk("t5_done", done_cnt, 1);
    chk("t5_exp_empty", exp_q.size(), 0);
    ready_mode = 0; tx_ready = 1'b1;

    // Two queued pages, lengths 2 and 3
    start_test();
    add_page(16'h3002, 0);
    add_page(16'h5003, 0);
    wait_idle(200);
    chk("t6_sent", sent, 5);
    chk("t6_done", done_cnt, 2);
    chk("t6_exp_empty", exp_q.size(), 0);

    // en low in IDLE holds off a pending page; en low mid-page does not stop it
    start_test(); en = 1'b0;
    add_page(16'h0004, 0);
    repeat (5) tick();
    chk("t7_held_off", busy, 0);
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_idle(100);
    chk("t7_sent", sent, 4);
    chk("t7_done", done_cnt, 1);
    en = 1'b1;

    // Abort after 2 of 10 bytes
    start_test();
    add_page(16'h000A, 0);
    wait_sent(2, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete(); exp_f_q.delete();
    chk("t8_txv_low", tx_valid, 0);
    wait_idle(50);
    chk("t8_all", all_cnt, 1);
    chk("t8_no_done", done_cnt, 0);

    // Abort in the same cycle as the final-byte handshake
    start_test(); tx_ready = 1'b0;
    add_page(16'h0001, 0);
    n = 0;
    while (!tx_valid && n < 50) begin tick(); n++; end
    chk("t9_valid_seen", tx_valid, 1);
    tx_ready = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(50);
    chk("t9_sent", sent, 1);
    chk("t9_all", all_cnt, 1);
    chk("t9_no_done", done_cnt, 0);
    chk("t9_exp_empty", exp_q.size(), 0);

    // Abort while idle still pulses the release
    start_test();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("t10_all", all_cnt, 1);
    chk("t10_idle", busy, 0);

    // Random pages with random sink backpressure
    start_test(); ready_mode = 1;
    for (int p = 0; p < 5; p++) begin
      f = 16'($urandom_range(0, 65535));
      f[8:0] = 9'($urandom_range(0, 14));
      add_page(f, 0);
    end
    wait_idle(1500);
    chk("t11_done", done_cnt, 5);
    chk("t11_exp_empty", exp_q.size(), 0);
    ready_mode = 0; tx_ready = 1'b1;

    // Reset mid-stream
    start_test();
    add_page(16'h000A, 0);
    wait_sent(3, 100);
    reset_n = 1'b0;
    #1;
    chk("t12_tx_valid", tx_valid, 0);
    chk("t12_tx_data", tx_data, 0);
    chk("t12_tx_last", tx_last, 0);
    chk("t12_rd_addr", rd_addr, 0);
    chk("t12_rd_en", rd_en, 0);
    chk("t12_cur_flags", cur_flags, 0);
    chk("t12_busy", busy, 0);
    hold_pending = 1'b0;
    tick(); tick();
    exp_q.delete(); exp_f_q.delete();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("t12_no_done", done_cnt, 0);
    chk("t12_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
